// File: rtl/spi_frame_pkg.sv
// -----------------------------------------------------------------------------
// spi_frame_pkg
// Shared definitions for the SPI frame receiver:
//   - target_e    : SPI_A target codes (config, mouse, kempston, keyboard)
//   - state_e     : receiver FSM states
//   - LEN_*       : expected frame lengths in bits, per target
//   - CFG_*_BIT   : bit positions inside the CFG register; every function they
//                   control is inactive when the bit is 0, so CFG=0x00 out of
//                   reset releases WAIT, unlocks memory and disables the mouse
//                   and keyboard paths
//   - frame_len() : maps a target to its expected frame length
// -----------------------------------------------------------------------------
package spi_frame_pkg;

  typedef enum logic [1:0] {
    TGT_CFG   = 2'b00,
    TGT_MOUSE = 2'b01,
    TGT_KMPST = 2'b10,
    TGT_KBD   = 2'b11
  } target_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_COMMIT
  } state_e;

  localparam int unsigned SR_W  = 40;  // shift register width (longest frame)
  localparam int unsigned CNT_W = 6;   // bit counter width, saturates at 63

  localparam logic [CNT_W-1:0] LEN_CFG   = 6'd8;
  localparam logic [CNT_W-1:0] LEN_MOUSE = 6'd24;
  localparam logic [CNT_W-1:0] LEN_KMPST = 6'd8;
  localparam logic [CNT_W-1:0] LEN_KBD   = 6'd40;

  localparam int unsigned CFG_WAIT_BIT     = 0;  // 1 = hold the CPU in WAIT
  localparam int unsigned CFG_MEM_LOCK_BIT = 1;  // 1 = memory locked
  localparam int unsigned CFG_MOUSE_EN_BIT = 2;  // 1 = mouse path enabled
  localparam int unsigned CFG_KBD_EN_BIT   = 3;  // 1 = keyboard path enabled

  function automatic logic [CNT_W-1:0] frame_len(input target_e tgt);
    logic [CNT_W-1:0] len;
    unique case (tgt)
      TGT_CFG:   len = LEN_CFG;
      TGT_MOUSE: len = LEN_MOUSE;
      TGT_KMPST: len = LEN_KMPST;
      TGT_KBD:   len = LEN_KBD;
      default:   len = LEN_CFG;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/spi_frame_rx_if.sv
// -----------------------------------------------------------------------------
// spi_frame_rx_if
// Bundles the MCU-side SPI pins and the decoded register outputs of
// spi_frame_rx.
//   SPI_SCK, SPI_NSS, SPI_MOSI, SPI_A : asynchronous SPI pins from the MCU
//   CFG, MOUSE, KMPST, KBD            : committed target registers
//   UPD                               : one-cycle commit strobe per target
//   ERR, ERR_CNT                      : rejected-frame strobe and counter
// Modports: master = SPI source / register consumer, slave = receiver.
// -----------------------------------------------------------------------------
interface spi_frame_rx_if;
  logic        SPI_SCK;
  logic        SPI_NSS;
  logic        SPI_MOSI;
  logic [1:0]  SPI_A;
  logic [7:0]  CFG;
  logic [23:0] MOUSE;
  logic [7:0]  KMPST;
  logic [39:0] KBD;
  logic [3:0]  UPD;
  logic        ERR;
  logic [3:0]  ERR_CNT;

  modport master (
    output SPI_SCK, SPI_NSS, SPI_MOSI, SPI_A,
    input  CFG, MOUSE, KMPST, KBD, UPD, ERR, ERR_CNT
  );

  modport slave (
    input  SPI_SCK, SPI_NSS, SPI_MOSI, SPI_A,
    output CFG, MOUSE, KMPST, KBD, UPD, ERR, ERR_CNT
  );
endinterface

// File: rtl/spi_sync.sv
// -----------------------------------------------------------------------------
// spi_sync
// Multi-flop synchronizer bringing one asynchronous SPI input into the
// CLK14M domain.
//   clk, rst_n : clock and asynchronous active-low reset
//   i_d        : asynchronous input (WIDTH bits)
//   o_q        : synchronized output, STAGES clk cycles later
// RST_VAL presets every stage so that no false edge appears after reset.
// -----------------------------------------------------------------------------
module spi_sync #(
  parameter int                STAGES  = 2,
  parameter int                WIDTH   = 1,
  parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_sync [STAGES];

  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples the previous stage's old value; blocking here would collapse
  // the chain into a single flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) r_sync[i] <= RST_VAL;
    end else begin
      r_sync[0] <= i_d;
      for (int i = 1; i < STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/spi_frame_rx.sv
// -----------------------------------------------------------------------------
// spi_frame_rx
// Receives MSB-first SPI frames from the MCU and commits them to one of four
// target registers selected by SPI_A at the start of the frame.
//   CLK14M : sole clock
//   RST_N  : asynchronous active-low reset
//   bus    : spi_frame_rx_if.slave (SPI pins in, target registers out)
// A frame whose bit count does not match the target's length is rejected:
// targets stay unchanged, ERR pulses and ERR_CNT increments (saturating when
// ERR_SAT=1, wrapping otherwise). Commit latency from the NSS pin rising to
// the output update is SYNC_STAGES+2 cycles.
// -----------------------------------------------------------------------------
module spi_frame_rx
  import spi_frame_pkg::*;
#(
  parameter int SYNC_STAGES = 2,   // 2 or 3
  parameter bit ERR_SAT     = 1'b1
) (
  input logic          CLK14M,
  input logic          RST_N,
  spi_frame_rx_if.slave bus
);

  // ---------------------------------------------------------------- sync
  logic       w_sck;
  logic       w_nss;
  logic       w_mosi;
  logic [1:0] w_a;

  spi_sync #(.STAGES(SYNC_STAGES), .WIDTH(1), .RST_VAL(1'b1)) u_sync_sck (
    .clk(CLK14M), .rst_n(RST_N), .i_d(bus.SPI_SCK), .o_q(w_sck)
  );
  spi_sync #(.STAGES(SYNC_STAGES), .WIDTH(1), .RST_VAL(1'b1)) u_sync_nss (
    .clk(CLK14M), .rst_n(RST_N), .i_d(bus.SPI_NSS), .o_q(w_nss)
  );
  spi_sync #(.STAGES(SYNC_STAGES), .WIDTH(1), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(CLK14M), .rst_n(RST_N), .i_d(bus.SPI_MOSI), .o_q(w_mosi)
  );
  spi_sync #(.STAGES(SYNC_STAGES), .WIDTH(2), .RST_VAL(2'b11)) u_sync_a (
    .clk(CLK14M), .rst_n(RST_N), .i_d(bus.SPI_A), .o_q(w_a)
  );

  // --------------------------------------------------------- edge detect
  // Previous samples reset high to match the synchronizer presets, so the
  // first cycles after reset never show a spurious edge.
  logic r_sck_prev;
  logic r_nss_prev;

  always_ff @(posedge CLK14M or negedge RST_N) begin
    if (!RST_N) begin
      r_sck_prev <= 1'b1;
      r_nss_prev <= 1'b1;
    end else begin
      r_sck_prev <= w_sck;
      r_nss_prev <= w_nss;
    end
  end

  logic w_sck_rise;
  logic w_nss_fall;
  logic w_nss_rise;

  assign w_sck_rise = w_sck & ~r_sck_prev;
  assign w_nss_fall = ~w_nss & r_nss_prev;
  assign w_nss_rise = w_nss & ~r_nss_prev;

  // ------------------------------------------------------------------ FSM
  state_e r_state;
  state_e w_next;
  logic   w_start;
  logic   r_pend;   // NSS fall seen during COMMIT, start on the next IDLE

  always_ff @(posedge CLK14M or negedge RST_N) begin
    if (!RST_N) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // NOTE: every output of this block gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_nss_fall || r_pend) begin
          w_next  = ST_SHIFT;
          w_start = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (w_nss_rise) w_next = ST_COMMIT;
      end
      ST_COMMIT: w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // ------------------------------------------------------------ datapath
  target_e          r_tgt;
  logic [CNT_W-1:0] r_cnt;
  logic [SR_W-1:0]  r_sr;
  logic [7:0]       r_cfg;
  logic [23:0]      r_mouse;
  logic [7:0]       r_kmpst;
  logic [39:0]      r_kbd;
  logic [3:0]       r_upd;
  logic             r_err;
  logic [3:0]       r_err_cnt;

  always_ff @(posedge CLK14M or negedge RST_N) begin
    if (!RST_N) begin
      r_tgt     <= TGT_CFG;
      r_cnt     <= '0;
      r_sr      <= '0;
      r_pend    <= 1'b0;
      r_cfg     <= 8'h00;
      r_mouse   <= '0;
      r_kmpst   <= '0;
      r_kbd     <= '0;
      r_upd     <= '0;
      r_err     <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      // Strobes are high only for the single cycle after COMMIT.
      r_upd <= '0;
      r_err <= 1'b0;

      unique case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_tgt  <= target_e'(w_a);
            r_cnt  <= '0;
            r_sr   <= '0;
            r_pend <= 1'b0;
          end
        end

        ST_SHIFT: begin
          // An SCK rise coinciding with the NSS rise belongs to no frame.
          if (w_sck_rise && !w_nss_rise) begin
            r_sr <= {r_sr[SR_W-2:0], w_mosi};
            if (r_cnt != '1) r_cnt <= r_cnt + 6'd1;
          end
        end

        ST_COMMIT: begin
          if (w_nss_fall) r_pend <= 1'b1;
          if (r_cnt == frame_len(r_tgt)) begin
            unique case (r_tgt)
              TGT_CFG:   r_cfg   <= r_sr[7:0];
              TGT_MOUSE: r_mouse <= r_sr[23:0];
              TGT_KMPST: r_kmpst <= r_sr[7:0];
              TGT_KBD:   r_kbd   <= ~r_sr;   // matrix stored as 1 = pressed
              default: ;
            endcase
            r_upd[r_tgt] <= 1'b1;
          end else begin
            r_err <= 1'b1;
            if (!(ERR_SAT && (r_err_cnt == 4'hF))) r_err_cnt <= r_err_cnt + 4'd1;
          end
        end

        default: ;
      endcase
    end
  end

  assign bus.CFG     = r_cfg;
  assign bus.MOUSE   = r_mouse;
  assign bus.KMPST   = r_kmpst;
  assign bus.KBD     = r_kbd;
  assign bus.UPD     = r_upd;
  assign bus.ERR     = r_err;
  assign bus.ERR_CNT = r_err_cnt;

endmodule

// File: tb/tb_spi_frame_rx.sv
// -----------------------------------------------------------------------------
// tb_spi_frame_rx
// Self-checking bench for spi_frame_rx: a table of hand-computed frames,
// hand-written sequences for saturation, back-to-back frames and reset
// mid-frame, and randomized frames checked against a frame-level model.
// -----------------------------------------------------------------------------
module tb_spi_frame_rx;

  localparam int SYNC = 2;
  localparam int EXP_LAT = SYNC + 2;

  logic clk = 1'b0;
  logic RST_N = 1'b0;

  always #5 clk = ~clk;

  spi_frame_rx_if bus ();

  spi_frame_rx #(.SYNC_STAGES(SYNC), .ERR_SAT(1'b1)) dut (
    .CLK14M(clk),
    .RST_N (RST_N),
    .bus   (bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ------------------------------------------------------ pulse monitor
  int upd_cnt [4] = '{0, 0, 0, 0};
  int err_pulses  = 0;

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) if (bus.UPD[i] === 1'b1) upd_cnt[i]++;
    if (bus.ERR === 1'b1) err_pulses++;
  end

  // ---------------------------------------------------------- ref model
  logic [7:0]  m_cfg   = '0;
  logic [23:0] m_mouse = '0;
  logic [7:0]  m_kmpst = '0;
  logic [39:0] m_kbd   = '0;
  int          m_ecnt  = 0;

  task automatic model_reset();
    m_cfg = '0; m_mouse = '0; m_kmpst = '0; m_kbd = '0; m_ecnt = 0;
  endtask

  // A frame of n bits (n <= 40) leaves the last n bits sent, i.e. the low n
  // bits of d, in the receiver.
  task automatic model_apply(input logic [1:0] a, input int n, input logic [39:0] d,
                             output logic [3:0] e_upd, output bit e_err);
    logic [39:0] got;
    int          len;
    got = (n >= 40) ? d : (d & ((40'd1 << n) - 40'd1));
    len = (a == 2'd0) ? 8 : (a == 2'd1) ? 24 : (a == 2'd2) ? 8 : 40;
    e_upd = '0;
    e_err = 1'b0;
    if (n == len) begin
      e_upd[a] = 1'b1;
      case (a)
        2'd0:    m_cfg   = got[7:0];
        2'd1:    m_mouse = got[23:0];
        2'd2:    m_kmpst = got[7:0];
        default: m_kbd   = ~got;
      endcase
    end else begin
      e_err = 1'b1;
      if (m_ecnt < 15) m_ecnt++;
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".cfg"},     64'(bus.CFG),     64'(m_cfg));
    check({tag, ".mouse"},   64'(bus.MOUSE),   64'(m_mouse));
    check({tag, ".kmpst"},   64'(bus.KMPST),   64'(m_kmpst));
    check({tag, ".kbd"},     64'(bus.KBD),     64'(m_kbd));
    check({tag, ".err_cnt"}, 64'(bus.ERR_CNT), 64'(m_ecnt));
  endtask

  // ----------------------------------------------------------- stimulus
  task automatic send_bit(input logic b);
    bus.SPI_MOSI = b;
    repeat (3) @(negedge clk);
    bus.SPI_SCK = 1'b1;
    repeat (3) @(negedge clk);
    bus.SPI_SCK = 1'b0;
  endtask

  // Ends with NSS driven high on a negedge; SPI_A is flipped after the first
  // bit to show a mid-frame change has no effect.
  task automatic send_frame(input logic [1:0] a, input int n, input logic [39:0] d);
    @(negedge clk);
    bus.SPI_A   = a;
    bus.SPI_NSS = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = n - 1; i >= 0; i--) begin
      send_bit(d[i]);
      if (i == n - 1) bus.SPI_A = ~a;
    end
    repeat (3) @(negedge clk);
    bus.SPI_NSS = 1'b1;
  endtask

  // Counts clk rising edges from the NSS pin rise until a strobe appears.
  task automatic wait_commit(output int lat);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (bus.UPD != 4'd0 || bus.ERR) begin
        lat = k;
        break;
      end
    end
  endtask

  // One frame with latency and strobe-count checks.
  task automatic do_frame(input string tag, input logic [1:0] a, input int n,
                          input logic [39:0] d, input logic [3:0] e_upd, input bit e_err);
    int snap [4];
    int snap_err;
    int lat;
    logic [31:0] got_p, exp_p;
    for (int i = 0; i < 4; i++) snap[i] = upd_cnt[i];
    snap_err = err_pulses;
    send_frame(a, n, d);
    wait_commit(lat);
    repeat (4) @(negedge clk);
    check({tag, ".latency"}, 64'(lat), 64'(EXP_LAT));
    for (int i = 0; i < 4; i++) begin
      got_p[i*8 +: 8] = 8'(upd_cnt[i] - snap[i]);
      exp_p[i*8 +: 8] = {7'd0, e_upd[i]};
    end
    check({tag, ".upd_pulses"}, 64'(got_p), 64'(exp_p));
    check({tag, ".err_pulses"}, 64'(err_pulses - snap_err), 64'(e_err));
  endtask

  task automatic model_frame(input string tag, input logic [1:0] a, input int n,
                             input logic [39:0] d);
    logic [3:0] e_upd;
    bit         e_err;
    model_apply(a, n, d, e_upd, e_err);
    do_frame(tag, a, n, d, e_upd, e_err);
    check_model(tag);
  endtask

  function automatic logic [39:0] tgt_val(input logic [1:0] a);
    case (a)
      2'd0:    return 40'(bus.CFG);
      2'd1:    return 40'(bus.MOUSE);
      2'd2:    return 40'(bus.KMPST);
      default: return bus.KBD;
    endcase
  endfunction

  // -------------------------------------------------------------- table
  typedef struct {
    logic [1:0]  a;
    int          n;
    logic [39:0] data;
    logic [3:0]  exp_upd;
    bit          exp_err;
    logic [39:0] exp_val;
    logic [3:0]  exp_ecnt;
  } vec_t;

  vec_t vecs [9];

  initial begin
    logic [3:0] e_upd;
    bit         e_err;
    int         snap0, snap2, snap1, snap_err;

    vecs[0] = '{2'd0,  8, 40'hA5,         4'b0001, 1'b0, 40'hA5,         4'd0};
    vecs[1] = '{2'd1, 24, 40'h123456,     4'b0010, 1'b0, 40'h123456,     4'd0};
    vecs[2] = '{2'd3, 40, 40'hFFFFFFFFFF, 4'b1000, 1'b0, 40'h0000000000, 4'd0};
    vecs[3] = '{2'd3, 40, 40'hFFFFFFFFFE, 4'b1000, 1'b0, 40'h0000000001, 4'd0};
    vecs[4] = '{2'd2,  7, 40'h55,         4'b0000, 1'b1, 40'h00,         4'd1};
    vecs[5] = '{2'd2,  8, 40'h3C,         4'b0100, 1'b0, 40'h3C,         4'd1};
    vecs[6] = '{2'd0,  0, 40'h0,          4'b0000, 1'b1, 40'hA5,         4'd2};
    vecs[7] = '{2'd1, 25, 40'h1ABCDEF,    4'b0000, 1'b1, 40'h123456,     4'd3};
    vecs[8] = '{2'd3, 39, 40'h12345678,   4'b0000, 1'b1, 40'h0000000001, 4'd4};

    bus.SPI_SCK  = 1'b0;
    bus.SPI_NSS  = 1'b1;
    bus.SPI_MOSI = 1'b0;
    bus.SPI_A    = 2'd0;

    // Reset state, held low
    repeat (4) @(negedge clk);
    check("rst.cfg",     64'(bus.CFG),     64'h0);
    check("rst.mouse",   64'(bus.MOUSE),   64'h0);
    check("rst.kmpst",   64'(bus.KMPST),   64'h0);
    check("rst.kbd",     64'(bus.KBD),     64'h0);
    check("rst.upd_err", 64'({bus.UPD, bus.ERR}), 64'h0);
    check("rst.err_cnt", 64'(bus.ERR_CNT), 64'h0);
    RST_N = 1'b1;
    repeat (5) @(negedge clk);
    check("post_rst.no_strobe", 64'(upd_cnt[0] + upd_cnt[1] + upd_cnt[2] + upd_cnt[3] + err_pulses), 64'h0);

    // Hand-computed frames
    for (int i = 0; i < 9; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      model_apply(vecs[i].a, vecs[i].n, vecs[i].data, e_upd, e_err);
      do_frame(tag, vecs[i].a, vecs[i].n, vecs[i].data, vecs[i].exp_upd, vecs[i].exp_err);
      check({tag, ".target"},  64'(tgt_val(vecs[i].a)), 64'(vecs[i].exp_val));
      check({tag, ".err_cnt"}, 64'(bus.ERR_CNT),        64'(vecs[i].exp_ecnt));
      check_model(tag);
    end

    // Error counter saturation: 20 more bad kempston frames
    for (int i = 0; i < 20; i++) begin
      model_apply(2'd2, 1, 40'h1, e_upd, e_err);
      send_frame(2'd2, 1, 40'h1);
      repeat (10) @(negedge clk);
    end
    check("sat.err_cnt", 64'(bus.ERR_CNT), 64'd15);
    check("sat.kmpst",   64'(bus.KMPST),   64'h3C);
    check_model("sat");

    // Back-to-back frames with a 3-cycle NSS-high gap
    snap0 = upd_cnt[0]; snap2 = upd_cnt[2]; snap_err = err_pulses;
    model_apply(2'd0, 8, 40'h81, e_upd, e_err);
    model_apply(2'd2, 8, 40'h7E, e_upd, e_err);
    send_frame(2'd0, 8, 40'h81);
    repeat (3) @(negedge clk);
    bus.SPI_A   = 2'd2;
    bus.SPI_NSS = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 7; i >= 0; i--) begin
      logic [7:0] b2;
      b2 = 8'h7E;
      send_bit(b2[i]);
    end
    repeat (3) @(negedge clk);
    bus.SPI_NSS = 1'b1;
    repeat (12) @(negedge clk);
    check("b2b.cfg",   64'(bus.CFG),   64'h81);
    check("b2b.kmpst", 64'(bus.KMPST), 64'h7E);
    check("b2b.upd0",  64'(upd_cnt[0] - snap0), 64'd1);
    check("b2b.upd2",  64'(upd_cnt[2] - snap2), 64'd1);
    check("b2b.err",   64'(err_pulses - snap_err), 64'd0);
    check_model("b2b");

    // Reset after 12 of 24 mouse bits, then a full frame
    snap1 = upd_cnt[1];
    @(negedge clk);
    bus.SPI_A   = 2'd1;
    bus.SPI_NSS = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 12; i++) send_bit(1'b1);
    RST_N = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst.cfg",     64'(bus.CFG),     64'h0);
    check("midrst.kbd",     64'(bus.KBD),     64'h0);
    check("midrst.err_cnt", 64'(bus.ERR_CNT), 64'h0);
    model_reset();
    bus.SPI_NSS = 1'b1;
    bus.SPI_SCK = 1'b0;
    repeat (3) @(negedge clk);
    RST_N = 1'b1;
    repeat (3) @(negedge clk);
    model_frame("midrst_full", 2'd1, 24, 40'hFFFFFF);
    check("midrst.mouse", 64'(bus.MOUSE), 64'hFFFFFF);
    check("midrst.upd1_total", 64'(upd_cnt[1] - snap1), 64'd1);

    // Randomized frames against the model
    for (int i = 0; i < 24; i++) begin
      logic [1:0]  a;
      int          n;
      logic [39:0] d;
      a = 2'($urandom_range(0, 3));
      d = {8'($urandom), 32'($urandom)};
      if ($urandom_range(0, 3) != 0) n = (a == 2'd1) ? 24 : (a == 2'd3) ? 40 : 8;
      else                           n = $urandom_range(0, 40);
      model_frame($sformatf("rnd%0d", i), a, n, d);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_frame_rx.md
SPI_FRAME_RX -- requirements
Module: spi_frame_rx

Interface
REQ-001 Parameter SYNC_STAGES, default 2, sets the synchronizer depth on every SPI input; legal values are 2 and 3.
REQ-002 Parameter ERR_SAT, default 1, makes the error counter saturate when 1 and wrap when 0.
REQ-003 CLK14M  in  1  sole clock, 14 MHz board clock.
REQ-004 RST_N  in  1  reset, asynchronous assert, active-low.
REQ-005 SPI_SCK  in  1  MCU SPI clock, asynchronous; data is sampled on its rising edge.
REQ-006 SPI_NSS  in  1  frame select, active-low, asynchronous.
REQ-007 SPI_MOSI  in  1  serial data, MSB first.
REQ-008 SPI_A  in  2  target select: 00 config, 01 mouse, 10 kempston, 11 keyboard.
REQ-009 CFG  out  8  configuration register.
REQ-010 MOUSE  out  24  mouse bytes, with {Y,X,B} at [23:16],[15:8],[7:0].
REQ-011 KMPST  out  8  kempston joystick byte.
REQ-012 KBD  out  40  keyboard matrix, stored inverted (1 = key pressed).
REQ-013 UPD  out  4  one-cycle commit strobe per target, with bit index equal to the SPI_A code.
REQ-014 ERR  out  1  one-cycle strobe on a rejected frame.
REQ-015 ERR_CNT  out  4  count of rejected frames.

Function
REQ-016 The block shall pass SPI_SCK, SPI_NSS, SPI_MOSI and SPI_A each through SYNC_STAGES flops on CLK14M before any use.
REQ-017 The block shall detect SCK rising edges and NSS falling and rising edges from the last two synchronized samples.
REQ-018 The state machine shall have three states: IDLE, SHIFT and COMMIT.
REQ-019 IDLE->SHIFT shall occur on an NSS fall; on that transition the block latches the synchronized SPI_A, clears the bit counter and clears the shift register.
REQ-020 In SHIFT, each SCK rise shall shift the 40-bit shift register left by one, load synchronized MOSI into bit 0 and increment the 6-bit bit counter.
REQ-021 The bit counter shall saturate at 63.
REQ-022 SHIFT->COMMIT shall occur on an NSS rise.
REQ-023 An SCK rise in the same cycle as the NSS rise shall be ignored.
REQ-024 Expected frame lengths shall be: config 8 bits, kempston 8 bits, mouse 24 bits, keyboard 40 bits.
REQ-025 In COMMIT with count equal to the expected length, the block shall load the target from the low bits of the shift register and pulse UPD[target] for one cycle.
REQ-026 A keyboard commit shall load the bitwise inverse of the shift register into KBD.
REQ-027 In COMMIT with count not equal to the expected length, the block shall leave all targets unchanged, pulse ERR and increment ERR_CNT.
REQ-028 ERR_CNT shall saturate at 15 when ERR_SAT=1 and wrap to 0 when ERR_SAT=0.
REQ-029 A zero-bit frame (NSS pulse with no SCK) shall count as an error.
REQ-030 COMMIT shall return to IDLE in the following cycle unconditionally.
REQ-031 An NSS fall seen while in COMMIT shall be taken in the next IDLE cycle; that frame's first SCK edge is not lost, provided it arrives at least 2 cycles after the NSS fall.
REQ-032 Commit latency shall be exactly SYNC_STAGES+2 CLK14M cycles from the NSS pin rising to the output update.
REQ-033 Outputs shall be registered and shall change only on the commit cycle, so that they are glitch-free for the downstream combinational decode.
REQ-034 The supported SCK frequency is at most CLK14M/4; SCK high and low phases shall each be at least 2 CLK14M periods.
REQ-035 A change of SPI_A mid-frame shall be ignored.

Reset
REQ-036 While RST_N is low, the block shall hold CFG=0x00, MOUSE=0, KMPST=0, KBD=0, UPD=0, ERR=0, ERR_CNT=0, all synchronizer flops at 1 except MOSI at 0, and the state at IDLE.
REQ-037 A reset asserted mid-frame shall discard the frame; after release, the block shall wait for a fresh NSS fall, since the synchronizers preset NSS high and no false edge can occur.
REQ-038 CFG=0x00 out of reset shall release WAIT, unlock memory and disable the mouse and keyboard paths.

Structure
REQ-039 The SPI_A target codes, the expected frame lengths and the CFG bit indices shall live in a shared package, spi_frame_pkg.
REQ-040 The synchronizer shall be a single sub-module, spi_sync, instantiated once per input with the SYNC_STAGES depth.

Verification
REQ-041 An 8-bit frame 0xA5 with SPI_A=00 shall produce CFG=0xA5, a single pulse on UPD[0], and ERR=0.
REQ-042 A 24-bit frame 0x123456 with SPI_A=01 shall produce MOUSE=0x123456 and a pulse on UPD[1]; KBD, CFG and KMPST shall be unchanged.
REQ-043 A 40-bit all-ones frame with SPI_A=11 shall produce KBD=0x0000000000; a following frame 0xFFFFFFFFFE shall produce KBD=0x0000000001.
REQ-044 A 7-bit frame with SPI_A=10 shall produce one ERR pulse and ERR_CNT=1 with KMPST unchanged; 20 bad frames shall leave ERR_CNT=15.
REQ-045 Reset asserted after 12 of 24 mouse bits, then a full 0xFFFFFF frame, shall leave MOUSE=0xFFFFFF with only one UPD[1] pulse in total.
REQ-046 Back-to-back 8-bit frames with a 3-cycle NSS-high gap, SPI_A 00 then 10, shall commit both frames with the correct data and no ERR.
